// File: rtl/clock_ctrl_if.sv
// clock_ctrl_if: raw pushbutton/switch inputs and tick/mode outputs of clock_ctrl
interface clock_ctrl_if;
  logic btn_pause;
  logic sw_adjust;
  logic sw_sel;
  logic tick_1hz;
  logic tick_2hz;
  logic tick_active;
  logic count_enable;
  logic use_2hz;
  logic sel_minutes;
  logic sel_seconds;
  modport master (
    output btn_pause, sw_adjust, sw_sel,
    input  tick_1hz, tick_2hz, tick_active, count_enable, use_2hz, sel_minutes, sel_seconds
  );
  modport slave (
    input  btn_pause, sw_adjust, sw_sel,
    output tick_1hz, tick_2hz, tick_active, count_enable, use_2hz, sel_minutes, sel_seconds
  );
endinterface

// File: rtl/clock_ctrl.sv
// clock_ctrl: 2 Hz / 1 Hz tick divider, pause toggle FSM and adjust-mode selection.
// Define CLOCK_CTRL_DEBOUNCE_EN to debounce btn_pause over DEBOUNCE_CYCLES samples.
module clock_ctrl #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic          clk,
  input logic          rst_n,
  clock_ctrl_if.slave  bus
);
  localparam int HALF = CLK_HZ / 2;
  localparam int CW   = $clog2(HALF);

  if (CLK_HZ < 4 || CLK_HZ % 2 != 0 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
    $error("clock_ctrl: CLK_HZ must be even and >= 4, DEBOUNCE_CYCLES >= 2");
  end

  typedef enum logic {RUN, PAUSED} state_e;

  logic [2:0]    sync1_q, sync2_q;
  logic [CW-1:0] div_q, div_d;
  logic          wrap;
  logic          phase_q, tick2_q, tick1_q, tick_act_q;
  logic          use2hz_q, sel_min_q, sel_sec_q;
  logic          lvl, prev_q, press;
  state_e        state_q, state_d;

  // two-flop synchronizers for {btn_pause, sw_adjust, sw_sel}
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus.btn_pause, bus.sw_adjust, bus.sw_sel};
      sync2_q <= sync1_q;
    end
  end

  assign wrap  = div_q == CW'(HALF - 1);
  assign div_d = wrap ? '0 : div_q + CW'(1);

  // free-running divider, phase flop and registered tick/mode outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q      <= '0;
      phase_q    <= 1'b0;
      tick2_q    <= 1'b0;
      tick1_q    <= 1'b0;
      tick_act_q <= 1'b0;
      use2hz_q   <= 1'b0;
      sel_min_q  <= 1'b0;
      sel_sec_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      phase_q    <= phase_q ^ wrap;
      tick2_q    <= wrap;
      tick1_q    <= wrap & phase_q;
      tick_act_q <= wrap & (use2hz_q | phase_q);
      use2hz_q   <= sync2_q[1];
      sel_min_q  <= sync2_q[1] & ~sync2_q[0];
      sel_sec_q  <= sync2_q[1] & sync2_q[0];
    end
  end

`ifdef CLOCK_CTRL_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  logic [DW-1:0] deb_q, deb_d;
  logic          lvl_q, lvl_d;

  // count consecutive samples differing from the accepted level; accept on the last one
  always_comb begin
    deb_d = '0;
    lvl_d = lvl_q;
    if (sync2_q[2] != lvl_q) begin
      if (deb_q == DW'(DEBOUNCE_CYCLES - 1)) lvl_d = sync2_q[2];
      else deb_d = deb_q + DW'(1);
    end
  end

  // debounce counter and accepted button level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      deb_q <= deb_d;
      lvl_q <= lvl_d;
    end
  end

  assign lvl = lvl_q;
`else
  assign lvl = sync2_q[2];
`endif

  // previous button level for rising-edge press detection
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else prev_q <= lvl;
  end

  assign press = lvl & ~prev_q;

  // pause FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else state_q <= state_d;
  end

  // each press toggles between RUN and PAUSED
  always_comb begin
    state_d = state_q;
    if (press) state_d = (state_q == RUN) ? PAUSED : RUN;
  end

  assign bus.tick_1hz     = tick1_q;
  assign bus.tick_2hz     = tick2_q;
  assign bus.tick_active  = tick_act_q;
  assign bus.count_enable = state_q == RUN;
  assign bus.use_2hz      = use2hz_q;
  assign bus.sel_minutes  = sel_min_q;
  assign bus.sel_seconds  = sel_sec_q;
endmodule
